// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous signal in clkin cycles.
// Optional expected-value check is compiled in with `define CLK_PERIOD_CHECK_EN.
module clk_period_meter #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 3,
  parameter int EXP_HIGH   = 1,
  parameter int TOL        = 1
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout,
  output logic             mismatch
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_q, s2_q, s3_q;
  logic             rise, fall;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             accept, fin_ok, fin_to;
  logic [CNT_W-1:0] cnt_inc;

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    accept    = 1'b0;
    fin_ok    = 1'b0;
    fin_to    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_d   = ARM;
          cnt_d     = '0;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
        end
      end
      ARM: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = HIGH;
        end else if (cnt_q == CNT_MAX) begin
          fin_to = 1'b1;
          high_d = '1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HIGH: begin
        if (fall) begin
          high_d  = cnt_inc;
          cnt_d   = cnt_inc;
          state_d = LOW;
        end else if (cnt_q == CNT_MAX) begin
          fin_to = 1'b1;
          high_d = '1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOW: begin
        if (rise) begin
          fin_ok   = 1'b1;
          period_d = cnt_inc;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          fin_to = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    // Saturation ends the measurement identically from any active state.
    if (fin_to) begin
      period_d  = '1;
      done_d    = 1'b1;
      timeout_d = 1'b1;
      busy_d    = 1'b0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      high_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s1_q      <= sig_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef CLK_PERIOD_CHECK_EN
  localparam logic [CNT_W-1:0] EXP_P = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);

  function automatic logic [CNT_W-1:0] absdiff(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  logic mismatch_q;
  logic mis_val;

  // high_q already holds the captured high time when the LOW-state rise arrives.
  assign mis_val = (absdiff(cnt_inc, EXP_P) > TOL_C) | (absdiff(high_q, EXP_H) > TOL_C);

  always_ff @(posedge clkin) begin
    if (reset || accept)
      mismatch_q <= 1'b0;
    else if (fin_to)
      mismatch_q <= 1'b1;
    else if (fin_ok)
      mismatch_q <= mis_val;
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign period    = period_q;
  assign high_time = high_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Downstream consumer of the divided-clock generators: measures the period and high time of a slower, asynchronous signal, such as a divided clock, in units of the fast reference clock `clkin`.
- Used on-chip and in benches to confirm divider ratio and duty cycle.
- Flow: one-shot measurement triggered by `start`; results held until the next measurement; one-cycle `done` pulse.

Parameters:
- CNT_W, 16, width of the cycle counter and of the result registers.
- EXP_PERIOD, 3, expected period in `clkin` cycles; used only by the optional check.
- EXP_HIGH, 1, expected high time in `clkin` cycles; used only by the optional check.
- TOL, 1, allowed absolute deviation in cycles for both checks.

Ports:
- clkin  input  1  reference clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sig_in  input  1  signal under measurement; asynchronous to `clkin`.
- start  input  1  one-cycle request to begin a measurement.
- busy  output  1  high from accepted `start` until `done`.
- done  output  1  one-cycle pulse when results update.
- period  output  CNT_W  `clkin` cycles between two consecutive `sig_in` rising edges.
- high_time  output  CNT_W  `clkin` cycles from a `sig_in` rise to the following fall.
- timeout  output  1  set with `done` if the counter saturated before the measurement completed.
- mismatch  output  1  set with `done` if the optional check fails; constant 0 when the feature is compiled out.

Behaviour:
- Synchronizer and edge detect:
  - `sig_in` passes through a 2-flop synchronizer, then a third register.
  - `rise` = s2 & ~s3; `fall` = ~s2 & s3.
  - The fixed 2-3 cycle latency cancels because all results are differences between edges.
- Reset (`reset` high at a `clkin` edge):
  - FSM to IDLE; counter = 0.
  - `busy`, `done`, `timeout`, `mismatch` = 0; `period`, `high_time` = 0.
  - Synchronizer flops = 0.
  - Reset mid-measurement aborts it and produces no `done`.
- FSM states: IDLE, ARM, HIGH, LOW.
- IDLE:
  - `start` → ARM, `busy` = 1, `timeout` and `mismatch` cleared.
  - `start` outside IDLE is ignored.
- ARM: waits for `rise`. On `rise`: counter = 0, → HIGH. A signal that is already high at `start` is not measured until its next rise.
- HIGH:
  - Counter increments each cycle.
  - On `fall`: `high_time` <= counter + 1, → LOW.
- LOW:
  - Counter increments each cycle.
  - On `rise`: `period` <= counter + 1, `done` = 1 for one cycle, `busy` = 0, → IDLE.
- Counting rule: for a synchronous `sig_in` high for H cycles and low for L cycles, `high_time` = H and `period` = H+L.
- Saturation:
  - In ARM, HIGH or LOW, if the counter reaches 2^CNT_W-1 with no terminating edge, the measurement ends.
  - `done` = 1, `timeout` = 1, `busy` = 0, → IDLE.
  - `period` = all ones; `high_time` = all ones unless already captured.
  - The ARM wait uses the same counter, cleared at `start`.
- Edge coincidences:
  - `start` and `rise` in the same cycle: the rise is not used; wait for the next one.
  - `rise` and `fall` cannot coincide after synchronization.
- Outputs are registered and hold their last values until the next `done` or `reset`.

Optional Feature:
- Macro: CLK_PERIOD_CHECK_EN.
- Defined:
  - At `done` without timeout, `mismatch` = (|period - EXP_PERIOD| > TOL) | (|high_time - EXP_HIGH| > TOL).
  - Comparison is unsigned-safe, done by subtracting the larger minus the smaller.
  - At `done` with timeout, `mismatch` = 1.
- Not defined: `mismatch` is tied to 0 and the comparators are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: `reset` high 2 cycles, `sig_in` toggling → all outputs 0, no `done`.
- Divide-by-3 pattern (`sig_in` synchronous, high 1 / low 2), `start` → `done` once, `period` = 3, `high_time` = 1, `busy` low after `done`, `mismatch` = 0 with the macro.
- Pattern high 2 / low 4 with defaults and the macro defined → `period` = 6, `high_time` = 2, `mismatch` = 1. Without the macro → `mismatch` = 0.
- CNT_W = 4, `sig_in` stuck at 0, `start` → after 15 counts `done` = 1, `timeout` = 1, `period` = 4'hF.
- `reset` asserted while in LOW → no `done`; outputs 0; a fresh `start` then measures correctly.
- Second `start` while `busy` → ignored; exactly one `done`; results from the first request.
